ram_bus_master: RTL and testbench

- Initiator for the shared single-port RAM bus: addr, bidirectional data, chip_select, write_enable, output_enable.
- Turns a simple valid/ready host request into correctly sequenced RAM bus cycles.
- Owns tri-state turnaround so the controller and the RAM never drive the data bus at the same time.
- Sits between the processor/datapath and the large RAM array; the host issues exactly one request at a time.

---
 rtl/ram_bus_master.sv | 118 +++++++++++
 tb/tb_ram_bus_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// Single-request initiator for the shared single-port RAM bus: converts a host
// valid/ready request into a WRITE, or a READ followed by a bus TURN cycle.
module ram_bus_master #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_chip_select,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable
);

  // Host handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; the host holds the request until then, and a
  // request offered while req_ready is low is neither accepted nor queued.

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  localparam int CW = $clog2(READ_LATENCY + 1);

  state_t                state;
  logic [CW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_en;

  // The bus is driven only from flops, so release on reset is immediate.
  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lat_cnt           <= '0;
      wdata_q           <= '0;
      drive_en          <= 1'b0;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_write        <= 1'b0;
      resp_rdata        <= '0;
      ram_addr          <= '0;
      ram_chip_select   <= 1'b0;
      ram_write_enable  <= 1'b0;
      ram_output_enable <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ram_addr        <= req_addr;
            wdata_q         <= req_wdata;
            req_ready       <= 1'b0;
            ram_chip_select <= 1'b1;
            if (req_write) begin
              state            <= WRITE;
              ram_write_enable <= 1'b1;
              drive_en         <= 1'b1;
            end else begin
              state             <= READ;
              ram_output_enable <= 1'b1;
              lat_cnt           <= CW'(READ_LATENCY);
            end
          end
        end
        WRITE: begin
          state            <= IDLE;
          ram_chip_select  <= 1'b0;
          ram_write_enable <= 1'b0;
          drive_en         <= 1'b0;
          req_ready        <= 1'b1;
          resp_valid       <= 1'b1;
          resp_write       <= 1'b1;
        end
        READ: begin
          // Counter reaching zero marks the edge where RAM data is valid.
          if (lat_cnt == '0) begin
            state             <= TURN;
            ram_chip_select   <= 1'b0;
            ram_output_enable <= 1'b0;
            resp_rdata        <= ram_data;
            resp_valid        <= 1'b1;
            resp_write        <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        TURN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_we_oe_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_write_enable && ram_output_enable));

  a_no_drive_while_oe : assert property (@(posedge clk) disable iff (!rst_n)
    !(drive_en && ram_output_enable));

  a_drive_only_in_write : assert property (@(posedge clk) disable iff (!rst_n)
    drive_en == (state == WRITE));

  a_resp_single_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |=> !resp_valid);

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3, each attached to a behavioural RAM with matching latency.
module tb_ram_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid [2];
  logic        req_write [2];
  logic [11:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic        resp_write[2];
  logic [15:0] resp_rdata[2];
  logic [11:0] ram_addr  [2];
  logic        cs[2], we[2], oe[2];
  wire  [15:0] ram_data0, ram_data1;
  logic [15:0] bus_val[2];

  assign bus_val[0] = ram_data0;
  assign bus_val[1] = ram_data1;

  ram_bus_master #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_write(resp_write[0]), .resp_rdata(resp_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_data(ram_data0), .ram_chip_select(cs[0]),
    .ram_write_enable(we[0]), .ram_output_enable(oe[0])
  );

  ram_bus_master #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_write(resp_write[1]), .resp_rdata(resp_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_data(ram_data1), .ram_chip_select(cs[1]),
    .ram_write_enable(we[1]), .ram_output_enable(oe[1])
  );

  function automatic int lat_of(input int b);
    return (b == 0) ? 1 : 3;
  endfunction

  // Behavioural RAM: data appears READ_LATENCY edges after read controls rise.
  logic [15:0] mem[2][4096];
  logic [15:0] rd[2];
  int          rcnt[2];

  assign ram_data0 = oe[0] ? rd[0] : 16'hzzzz;
  assign ram_data1 = oe[1] ? rd[1] : 16'hzzzz;

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (cs[b] && we[b]) mem[b][ram_addr[b]] <= bus_val[b];
      if (cs[b] && oe[b]) begin
        if (rcnt[b] + 1 >= lat_of(b)) rd[b] <= mem[b][ram_addr[b]];
        rcnt[b] <= rcnt[b] + 1;
      end else begin
        rcnt[b] <= 0;
      end
    end
  end

  // Scoreboard and checker
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic floating(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // Bus monitors: acceptance and response counts, mutual exclusion, float.
  int   acc_cnt[2];
  int   resp_cnt[2];
  logic prev_resp[2];

  initial begin
    for (int b = 0; b < 2; b++) begin
      acc_cnt[b] = 0; resp_cnt[b] = 0; prev_resp[b] = 1'b0; rcnt[b] = 0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (rst_n && req_valid[b] && req_ready[b]) acc_cnt[b]++;
  end

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (resp_valid[b]) resp_cnt[b]++;
      check("we_oe_excl", we[b] & oe[b], 1'b0);
      check("resp_pulse", prev_resp[b] & resp_valid[b], 1'b0);
      if (!we[b] && !oe[b]) check("bus_float", floating(bus_val[b]), 1'b1);
      prev_resp[b] = resp_valid[b];
    end
  end

  int   last_e0[2];
  logic last_wr[2];

  // Driver: called at a negedge; returns at the negedge where resp_valid is seen.
  task automatic txn(input int b, input logic wr, input logic [11:0] a,
                     input logic [15:0] d, input bit chk_gap, input bit hold);
    int e0;
    int k;
    req_valid[b] = 1'b1; req_write[b] = wr; req_addr[b] = a; req_wdata[b] = d;
    k = 0;
    while (!req_ready[b] && k < 20) begin @(negedge clk); k++; end
    if (!req_ready[b]) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid[b] = 1'b0;
      return;
    end
    @(negedge clk);
    e0 = cyc;
    if (!hold) req_valid[b] = 1'b0;
    if (chk_gap) check("accept_gap", e0 - last_e0[b], last_wr[b] ? 2 : lat_of(b) + 3);
    last_e0[b] = e0;
    last_wr[b] = wr;
    if (!wr) exp_q.push_back(d);
    check("ready_busy", req_ready[b], 1'b0);
    check("ram_addr", ram_addr[b], a);
    k = 0;
    while (!resp_valid[b] && k < 20) begin @(negedge clk); k++; end
    req_valid[b] = 1'b0;
    if (!resp_valid[b]) begin
      check("resp_timeout", 1'b0, 1'b1);
      return;
    end
    check("resp_latency", cyc - e0, wr ? 1 : lat_of(b) + 1);
    check("resp_write", resp_write[b], wr);
    if (wr) begin
      check("ready_after_wr", req_ready[b], 1'b1);
    end else begin
      check("rdata", resp_rdata[b], exp_q.pop_front());
      check("turn_ctrl", {cs[b], we[b], oe[b]}, 3'b000);
      check("turn_ready", req_ready[b], 1'b0);
    end
  endtask

  logic [15:0] quad[16];
  int          a0, r0, k;

  initial begin
    for (int b = 0; b < 2; b++) begin
      req_valid[b] = 1'b0; req_write[b] = 1'b0; req_addr[b] = '0; req_wdata[b] = '0;
      last_e0[b] = 0; last_wr[b] = 1'b0;
    end

    // Reset held while a request is forced
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h123; req_wdata[0] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready[0], 1'b1);
    check("rst_resp_valid", resp_valid[0], 1'b0);
    check("rst_resp_write", resp_write[0], 1'b0);
    check("rst_rdata", resp_rdata[0], 16'h0000);
    check("rst_addr", ram_addr[0], 12'h000);
    check("rst_ctrl", {cs[0], we[0], oe[0]}, 3'b000);
    check("rst_float", floating(bus_val[0]), 1'b1);
    check("rst_ready_l3", req_ready[1], 1'b1);
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_accept", acc_cnt[0], 0);

    // Single write then read
    txn(0, 1'b1, 12'h3FC, 16'hA5A5, 1'b0, 1'b0);
    txn(0, 1'b0, 12'h3FC, 16'hA5A5, 1'b1, 1'b0);

    // Boundary quartets, back-to-back
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 4; i++) begin
        quad[q*4+i] = 16'($urandom_range(0, 16'hFFFF));
        txn(0, 1'b1, 12'((q << 10) | 12'h3FC) + 12'(i), quad[q*4+i], 1'b1, 1'b0);
      end
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 4; i++)
        txn(0, 1'b0, 12'((q << 10) | 12'h3FC) + 12'(i), quad[q*4+i], 1'b1, 1'b0);

    // Read followed immediately by a write to the same address
    txn(0, 1'b1, 12'h000, 16'h5A5A, 1'b1, 1'b0);
    txn(0, 1'b0, 12'h000, 16'h5A5A, 1'b1, 1'b0);
    txn(0, 1'b1, 12'h000, 16'h1234, 1'b1, 1'b0);
    txn(0, 1'b0, 12'h000, 16'h1234, 1'b1, 1'b0);

    // Host keeps req_valid high through a busy read
    repeat (2) @(negedge clk);
    a0 = acc_cnt[0]; r0 = resp_cnt[0];
    txn(0, 1'b0, 12'h3FC, quad[0], 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("stall_accepts", acc_cnt[0] - a0, 1);
    check("stall_resps", resp_cnt[0] - r0, 1);
    txn(0, 1'b1, 12'h3FD, 16'h0F0F, 1'b0, 1'b0);
    check("rdata_hold", resp_rdata[0], quad[0]);
    txn(0, 1'b0, 12'h3FD, 16'h0F0F, 1'b1, 1'b0);

    // Reset in the middle of a read
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 12'h3FD;
    k = 0;
    while (!req_ready[0] && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_read_oe", oe[0], 1'b1);
    r0 = resp_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {cs[0], we[0], oe[0]}, 3'b000);
    check("abort_float", floating(bus_val[0]), 1'b1);
    check("abort_ready", req_ready[0], 1'b1);
    check("abort_rdata", resp_rdata[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_resp", resp_cnt[0] - r0, 0);
    txn(0, 1'b0, 12'h3FD, 16'h0F0F, 1'b0, 1'b0);

    // READ_LATENCY=3 instance
    txn(1, 1'b1, 12'hFFF, 16'hBEEF, 1'b0, 1'b0);
    txn(1, 1'b0, 12'hFFF, 16'hBEEF, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
